mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 101 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the 16-to-1 selector through channels 0..15, waits a
// programmable settle time on each enabled channel, samples the selector
// output once, and hands the assembled 16-bit word downstream.
//
// Handshake: data/valid are held stable while valid=1; a transfer happens on
// any rising edge where valid=1 and ready=1, after which valid drops. ready
// while valid=0 is ignored. start is honoured only while idle (busy=0).
module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 8 // cycles sel is held before sampling, 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mask,
    output logic [3:0]  sel,
    input  logic        mux_out,
    output logic [15:0] data,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH   = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] mask_q;
    // Bits 0..14 of the word under construction; bit 15 goes straight to data.
    logic [14:0] asm_q;

    logic ch_en;
    logic ch_done;
    logic ch_bit;

    // Current-channel decode: masked channels finish at once and contribute 0;
    // enabled channels finish (and sample mux_out) only when the settle count is reached.
    always_comb begin
        ch_en   = mask_q[sel];
        ch_done = !ch_en || (cnt == SETTLE);
        ch_bit  = ch_en && mux_out;
    end

    assign state_dbg = state;

    // Scan sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= 4'd0;
            cnt    <= 8'd0;
            mask_q <= 16'h0000;
            asm_q  <= 15'h0000;
            data   <= 16'h0000;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= mask;
                        sel    <= 4'd0;
                        cnt    <= 8'd0;
                        busy   <= 1'b1;
                        state  <= CH;
                    end
                end
                CH: begin
                    if (!ch_done) begin
                        cnt <= cnt + 8'd1;
                    end else if (sel != 4'd15) begin
                        asm_q[sel] <= ch_bit;
                        sel        <= sel + 4'd1;
                        cnt        <= 8'd0;
                    end else begin
                        data  <= {ch_bit, asm_q};
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ready) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural 60 ns selector, table of scans with
// fixed and random patterns/masks, plus hand-written backpressure, empty-mask
// and reset sequences.
module tb_mux_scan_ctrl;

    localparam int S      = 8;
    localparam int BUDGET = 400;
    localparam int NVEC   = 9;

    // clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [15:0] mask  = 16'h0000;
    logic [3:0]  sel;
    logic        mux_out;
    logic [15:0] data;
    logic        valid;
    logic        ready = 1'b0;
    logic        busy;
    logic [1:0]  state_dbg;

    // behavioural selector: output follows pat[sel] after 60 ns
    logic [15:0] pat    = 16'h0000;
    logic        mux_d;
    logic        tog    = 1'b0;
    logic        tog_en = 1'b0;
    assign #60 mux_d = pat[sel];
    assign mux_out = tog_en ? tog : mux_d;
    always #3 tog = tog_en ? ~tog : tog;

    mux_scan_ctrl #(.SETTLE_CYC(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mask      (mask),
        .sel       (sel),
        .mux_out   (mux_out),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    int hold[16];

    typedef struct {
        logic [15:0] pat;
        logic [15:0] mask;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;
    vec_t vecs[NVEC];

    // reference model: enabled channels cost S+1 cycles, masked ones 1 cycle
    function automatic int model_lat(input logic [15:0] m);
        int en = 0;
        for (int k = 0; k < 16; k++) en += int'(m[k]);
        return en * (S + 1) + (16 - en);
    endfunction

    function automatic int model_hold(input logic [15:0] m, input int k);
        return m[k] ? (S + 1) : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver: start a scan and count edges until valid, recording sel hold times
    task automatic run_scan(input logic [15:0] p, input logic [15:0] m, output int lat);
        pat = p;
        @(negedge clk);
        start = 1'b1;
        mask  = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mask  = 16'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) hold[k] = 0;
        lat = 0;
        while (!valid && lat < BUDGET) begin
            hold[sel] = hold[sel] + 1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (lat >= BUDGET) chk("scan_timeout", 32'(lat), 32'(model_lat(m)));
    endtask

    task automatic handshake(input logic [15:0] exp_data);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        chk("valid_after_xfer", 32'(valid), 32'd0);
        chk("busy_after_xfer", 32'(busy), 32'd0);
        chk("data_kept", 32'(data), 32'(exp_data));
    endtask

    initial begin
        int lat;
        int bad;

        // table: three fixed scans with hand-computed results, then random rows
        vecs[0] = '{pat: 16'hAB5C, mask: 16'hFFFF, exp_data: 16'hAB5C, exp_lat: 144};
        vecs[1] = '{pat: 16'hFFFF, mask: 16'h00F0, exp_data: 16'h00F0, exp_lat: 48};
        vecs[2] = '{pat: 16'h1234, mask: 16'hFFFF, exp_data: 16'h1234, exp_lat: 144};
        for (int i = 3; i < NVEC; i++) begin
            vecs[i].pat      = 16'($urandom);
            vecs[i].mask     = 16'($urandom);
            vecs[i].exp_data = vecs[i].pat & vecs[i].mask;
            vecs[i].exp_lat  = model_lat(vecs[i].mask);
        end

        // power-on reset values
        #2;
        chk("por_sel", 32'(sel), 32'd0);
        chk("por_data", 32'(data), 32'd0);
        chk("por_valid", 32'(valid), 32'd0);
        chk("por_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ready while idle must do nothing
        ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        chk("idle_ready_busy", 32'(busy), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_scan(vecs[i].pat, vecs[i].mask, lat);
            chk($sformatf("lat[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("data[%0d]", i), 32'(data), 32'(vecs[i].exp_data));
            chk($sformatf("valid[%0d]", i), 32'(valid), 32'd1);
            bad = 0;
            for (int k = 0; k < 16; k++)
                if (hold[k] != model_hold(vecs[i].mask, k)) bad++;
            chk($sformatf("sel_hold[%0d]", i), 32'(bad), 32'd0);
            handshake(vecs[i].exp_data);
        end

        // empty mask with a toggling selector output
        tog_en = 1'b1;
        run_scan(16'hFFFF, 16'h0000, lat);
        tog_en = 1'b0;
        chk("empty_lat", 32'(lat), 32'd16);
        chk("empty_data", 32'(data), 32'd0);
        handshake(16'h0000);

        // backpressure: 20 cycles of ready=0 with stray start pulses
        run_scan(16'hAB5C, 16'hFFFF, lat);
        chk("bp_lat", 32'(lat), 32'd144);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            mask  = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (valid !== 1'b1 || data !== 16'hAB5C || busy !== 1'b1 || sel !== 4'd15) bad++;
        end
        start = 1'b0;
        chk("bp_stable", 32'(bad), 32'd0);
        handshake(16'hAB5C);
        // start on the very next cycle is accepted
        start = 1'b1;
        mask  = 16'hFFFF;
        pat   = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_sel", 32'(sel), 32'd0);

        // reset mid-scan, asserted between clock edges
        repeat (49) @(negedge clk);
        chk("midscan_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // clean scan after the abort
        run_scan(16'h1234, 16'hFFFF, lat);
        chk("post_rst_lat", 32'(lat), 32'd144);
        chk("post_rst_data", 32'(data), 32'h1234);
        handshake(16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
